i2s_tdm_tx: RTL and testbench
=============================

Name: i2s_tdm_tx

Overview:
- Parametrised I2S/TDM audio serializer that drives the board-level I2S_BCK, I2S_LRCK and I2S_DATA pins from parallel PCM frames produced by the guest core.
- Successor to the fixed 2×16-bit stereo I2S output.
- Generalises sample width, slot width, channel count and framing mode.
- Adds a one-frame holding buffer with valid/ready handshake and underrun reporting.

Parameters:
- CLK_DIV, 4: clk_sys cycles per BCK half-period. Legal range is 1 or greater. BCK period = 2*CLK_DIV.
- SAMPLE_BITS, 16: significant bits per channel sample, two's complement, passed through unchanged.
- SLOT_BITS, 16: BCK cycles per channel slot. SLOT_BITS must be at least SAMPLE_BITS. Bits beyond the sample are zero padding.
- CHANNELS, 2: slots per frame. Must be even and at least 2. Channel 0 sits in in_data[SAMPLE_BITS-1:0].
- MODE, 0: framing mode. 0 = Philips I2S (one-BCK data delay after the LRCK edge). 1 = left-justified (MSB aligned with the LRCK edge).

Ports:
- clk_sys, in, 1: system clock.
- reset_n, in, 1: asynchronous, active-low reset.
- en, in, 1: serializer enable.
- in_data, in, CHANNELS*SAMPLE_BITS: one PCM frame.
- in_valid, in, 1: in_data is valid.
- in_ready, out, 1: holding buffer is empty.
- I2S_BCK, out, 1: bit clock.
- I2S_LRCK, out, 1: word select / frame sync.
- I2S_DATA, out, 1: serial data, MSB first.
- underrun, out, 1: one-cycle pulse when a frame started with an empty buffer.

Behaviour:
Derived values:
- FRAME_BITS = CHANNELS*SLOT_BITS.
- bit_cnt is $clog2(FRAME_BITS) wide.
- div_cnt is $clog2(CLK_DIV) wide, minimum 1 bit.

Reset (reset_n low, asynchronous):
- I2S_BCK=0, I2S_LRCK=0, I2S_DATA=0, underrun=0, in_ready=1.
- div_cnt=0, bit_cnt=FRAME_BITS-1.
- Shadow register and holding buffer are cleared to 0.
- Reset asserted mid-frame aborts the frame immediately. No partial data is retained.

Disable (en=0, synchronous):
- I2S_BCK, I2S_LRCK and I2S_DATA are held 0.
- div_cnt=0, bit_cnt=FRAME_BITS-1.
- The I2S delay flop is cleared.
- The holding buffer keeps its contents and still accepts data.

Bit clock:
- div_cnt counts 0..CLK_DIV-1.
- On the terminal count, div_cnt wraps and I2S_BCK toggles.

Falling BCK (BCK toggles 1→0, and the first toggle-low event after reset or en rise):
- bit_cnt increments, wrapping FRAME_BITS-1→0.
- I2S_DATA and I2S_LRCK update in the same clk_sys cycle as BCK.
- The receiver samples on rising BCK.
- First frame after reset: BCK rises first. The following fall wraps bit_cnt to 0 and starts frame 0. Before that, DATA and LRCK stay 0.

Frame start (bit_cnt wraps to 0):
- If the holding buffer is full: shadow ← buffer, buffer becomes empty, in_ready=1 from the next cycle.
- If the holding buffer is empty: shadow is unchanged (the last frame repeats) and underrun pulses for exactly one clk_sys cycle.

Handshake:
- A transfer occurs when in_valid && in_ready. The buffer is loaded and in_ready=0 on the next cycle.
- An accept in the same cycle as an empty-buffer frame start goes into the buffer only (no bypass). The underrun still fires.
- Latency: accepted data appears on I2S_DATA starting at the next frame start.

Slot mapping:
- For frame position p, slot s = p / SLOT_BITS and k = p mod SLOT_BITS.
- The left-justified bit is LJ(p) = shadow[s*SAMPLE_BITS + SAMPLE_BITS-1-k] when k < SAMPLE_BITS, and 0 otherwise.
- MODE=1: I2S_DATA = LJ(p).
- MODE=0: I2S_DATA = LJ(p-1) via a one-BCK delay flop. At p=0 it carries LJ(FRAME_BITS-1) of the previous frame (0 for the first frame).

LRCK:
- I2S_LRCK = 0 for p < FRAME_BITS/2 and 1 otherwise.
- For CHANNELS=2 this is standard left/right select.
- For CHANNELS>2 it is a 50% frame sync.

Test Plan:
1. Reset and enable. CLK_DIV=2, SAMPLE_BITS=16, SLOT_BITS=16, CHANNELS=2, MODE=1. Release reset_n with en=1 and no input. Required: BCK period 4 clk_sys; first BCK fall 4 cycles after release; DATA=0 throughout; underrun pulses once per 128-cycle frame.
2. Left-justified frame. Same parameters; push in_data={16'h0001, 16'hA5F0} before frame start. Required: in_ready drops the cycle after accept and returns 1 after load. Frame n+1 has LRCK=0 for 16 BCKs and DATA=1010010111110000, then LRCK=1 and DATA=0000000000000001. No underrun.
3. I2S delay. MODE=0, same data. Required: DATA at frame bit 0 is the previous frame's LSB (0), bits 1..16 are A5F0 MSB-first, bit 17 onward is 0001 shifted by one. LRCK edges are unchanged from scenario 2.
4. TDM padding and back-pressure. CHANNELS=4, SAMPLE_BITS=24, SLOT_BITS=32, MODE=1; hold in_valid=1 with four distinct values. Required: each slot carries 24 data bits then 8 zeros; LRCK is high for bits 64..127; in_ready=0 until frame start, so exactly one frame is accepted per 128 BCKs.
5. Underrun repeat. Stop in_valid after one frame. Required: the next frame repeats the same serial pattern; underrun is high for exactly 1 clk_sys at each such frame start.
6. Mid-frame abort. Assert reset_n low at bit 37, then release; separately drop en at bit 37. Required: all outputs are 0 within 0 cycles for reset and 1 cycle for en. On restart the frame begins at bit 0. With en, a buffered frame is preserved and transmitted first.

Source files
------------

// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx: parametrised I2S / left-justified / TDM serializer.
// A one-frame holding buffer (valid/ready) feeds a shadow register that is
// reloaded at every frame start; if the buffer is empty at that point the
// previous frame is repeated and a single-cycle underrun pulse is raised.
//
// Handshake: a frame transfers on a clk_sys edge where in_valid && in_ready;
// in_ready is simply "holding buffer empty", it does not depend on in_valid,
// and it goes low on the cycle after the transfer.
module i2s_tdm_tx #(
  parameter int CLK_DIV     = 4,
  parameter int SAMPLE_BITS = 16,
  parameter int SLOT_BITS   = 16,
  parameter int CHANNELS    = 2,
  parameter int MODE        = 0
) (
  input  logic                            clk_sys,
  input  logic                            reset_n,
  input  logic                            en,
  input  logic [CHANNELS*SAMPLE_BITS-1:0] in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            I2S_BCK,
  output logic                            I2S_LRCK,
  output logic                            I2S_DATA,
  output logic                            underrun
);

  localparam int FRAME_BITS = CHANNELS * SLOT_BITS;
  localparam int DATA_W     = CHANNELS * SAMPLE_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(FRAME_BITS / 2);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Clock divider / frame position state
  logic [DIV_W-1:0]  div_q, div_d;
  logic              bck_q, bck_d;
  logic [CNT_W-1:0]  bit_q, bit_d;

  // Frame storage
  logic              full_q, full_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;

  // Serial outputs and the one-BCK delay flop used by Philips framing
  logic              lrck_q, lrck_d;
  logic              data_q, data_d;
  logic              dly_q, dly_d;
  logic              und_q, und_d;

  // Control strobes
  logic              bck_fall;
  logic              frame_start;

  // Left-justified bit for every frame position, taken from the shadow value
  // that is valid after this edge (so frame bit 0 already sees a fresh load).
  logic [FRAME_BITS-1:0] lj_vec;

  for (genvar s = 0; s < CHANNELS; s++) begin : g_slot
    for (genvar k = 0; k < SLOT_BITS; k++) begin : g_bit
      if (k < SAMPLE_BITS) begin : g_data
        assign lj_vec[s*SLOT_BITS + k] = shadow_d[s*SAMPLE_BITS + SAMPLE_BITS - 1 - k];
      end else begin : g_pad
        assign lj_vec[s*SLOT_BITS + k] = 1'b0;
      end
    end
  end

  // Bit clock divider, frame position, buffer/shadow handoff and underrun
  always_comb begin
    div_d       = div_q;
    bck_d       = bck_q;
    bit_d       = bit_q;
    full_d      = full_q;
    buf_d       = buf_q;
    shadow_d    = shadow_q;
    und_d       = 1'b0;
    bck_fall    = 1'b0;
    frame_start = 1'b0;

    if (!en) begin
      div_d = '0;
      bck_d = 1'b0;
      bit_d = BIT_LAST;
    end else if (div_q == DIV_LAST) begin
      div_d    = '0;
      bck_d    = ~bck_q;
      bck_fall = bck_q;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    if (bck_fall) begin
      if (bit_q == BIT_LAST) begin
        bit_d       = '0;
        frame_start = 1'b1;
      end else begin
        bit_d = bit_q + CNT_W'(1);
      end
    end

    // A full buffer moves into the shadow; an empty one repeats the last frame.
    if (frame_start) begin
      if (full_q) begin
        shadow_d = buf_q;
        full_d   = 1'b0;
      end else begin
        und_d = 1'b1;
      end
    end

    // Accept only into an empty buffer; never bypass into the shadow.
    if (in_valid && !full_q) begin
      buf_d  = in_data;
      full_d = 1'b1;
    end
  end

  // LRCK and DATA change together with the falling BCK edge
  always_comb begin
    lrck_d = lrck_q;
    data_d = data_q;
    dly_d  = dly_q;
    if (!en) begin
      lrck_d = 1'b0;
      data_d = 1'b0;
      dly_d  = 1'b0;
    end else if (bck_fall) begin
      lrck_d = (bit_d >= BIT_HALF);
      if (MODE != 0) begin
        data_d = lj_vec[bit_d];
      end else begin
        data_d = dly_q;
        dly_d  = lj_vec[bit_d];
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      bck_q    <= 1'b0;
      bit_q    <= BIT_LAST;
      full_q   <= 1'b0;
      buf_q    <= '0;
      shadow_q <= '0;
      lrck_q   <= 1'b0;
      data_q   <= 1'b0;
      dly_q    <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      bck_q    <= bck_d;
      bit_q    <= bit_d;
      full_q   <= full_d;
      buf_q    <= buf_d;
      shadow_q <= shadow_d;
      lrck_q   <= lrck_d;
      data_q   <= data_d;
      dly_q    <= dly_d;
      und_q    <= und_d;
    end
  end

  assign in_ready = ~full_q;
  assign I2S_BCK  = bck_q;
  assign I2S_LRCK = lrck_q;
  assign I2S_DATA = data_q;
  assign underrun = und_q;

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// tb_i2s_tdm_tx: three serializer configurations side by side
//   dut 0 (a): CLK_DIV=2, 2 x 16/16, left-justified
//   dut 1 (b): CLK_DIV=2, 2 x 16/16, Philips I2S
//   dut 2 (c): CLK_DIV=1, 4 x 24/32, left-justified TDM
// A receiver task records DATA/LRCK on every rising BCK; rise 0 precedes
// frame 0, rise 1 + f*FRAME_BITS + p carries frame f bit p.
module tb_i2s_tdm_tx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        en_a, en_b, en_c;
  logic [31:0] din_a, din_b;
  logic [95:0] din_c;
  logic        val_a, val_b, val_c;
  logic        rdy_a, rdy_b, rdy_c;
  logic        bck_a, bck_b, bck_c;
  logic        lrck_a, lrck_b, lrck_c;
  logic        dat_a, dat_b, dat_c;
  logic        und_a, und_b, und_c;

  i2s_tdm_tx #(.CLK_DIV(2), .SAMPLE_BITS(16), .SLOT_BITS(16), .CHANNELS(2), .MODE(1)) u_a (
    .clk_sys(clk), .reset_n(reset_n), .en(en_a), .in_data(din_a), .in_valid(val_a),
    .in_ready(rdy_a), .I2S_BCK(bck_a), .I2S_LRCK(lrck_a), .I2S_DATA(dat_a), .underrun(und_a));

  i2s_tdm_tx #(.CLK_DIV(2), .SAMPLE_BITS(16), .SLOT_BITS(16), .CHANNELS(2), .MODE(0)) u_b (
    .clk_sys(clk), .reset_n(reset_n), .en(en_b), .in_data(din_b), .in_valid(val_b),
    .in_ready(rdy_b), .I2S_BCK(bck_b), .I2S_LRCK(lrck_b), .I2S_DATA(dat_b), .underrun(und_b));

  i2s_tdm_tx #(.CLK_DIV(1), .SAMPLE_BITS(24), .SLOT_BITS(32), .CHANNELS(4), .MODE(1)) u_c (
    .clk_sys(clk), .reset_n(reset_n), .en(en_c), .in_data(din_c), .in_valid(val_c),
    .in_ready(rdy_c), .I2S_BCK(bck_c), .I2S_LRCK(lrck_c), .I2S_DATA(dat_c), .underrun(und_c));

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            errors = 0;
  logic          rx_d[$];
  logic          rx_l[$];
  int            rise_cyc[$];
  int            und_cyc[$];
  int            acc_cyc[$];
  int            first_fall;
  logic [127:0]  exp_q[$];

  typedef struct {
    int           dut;
    int           pre;
    logic [95:0]  din;
    logic [127:0] exp0;
    logic [127:0] exp1;
    int           und;
  } vec_t;

  localparam int NV = 7;
  vec_t vt[NV];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int fb_of(input int dut);
    return (dut == 2) ? 128 : 32;
  endfunction

  function automatic int div_of(input int dut);
    return (dut == 2) ? 1 : 2;
  endfunction

  function automatic logic [127:0] lrck_exp(input int fb);
    return (128'd1 << (fb / 2)) - 128'd1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int dut, input logic v, input logic [95:0] d);
    case (dut)
      0:       begin val_a = v; din_a = d[31:0]; end
      1:       begin val_b = v; din_b = d[31:0]; end
      default: begin val_c = v; din_c = d; end
    endcase
  endtask

  task automatic sample(input int dut, output logic b, output logic l, output logic d,
                        output logic u, output logic r);
    case (dut)
      0:       begin b = bck_a; l = lrck_a; d = dat_a; u = und_a; r = rdy_a; end
      1:       begin b = bck_b; l = lrck_b; d = dat_b; u = und_b; r = rdy_b; end
      default: begin b = bck_c; l = lrck_c; d = dat_c; u = und_c; r = rdy_c; end
    endcase
  endtask

  // Leaves reset released at a falling clk edge with valid low and en high.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    drive(2, 1'b0, '0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Offer one frame (valid held until ready), then check ready drops.
  task automatic push(input int dut, input logic [95:0] d, input int pre);
    int   w;
    logic b, l, dd, u, r;
    repeat (pre) @(negedge clk);
    drive(dut, 1'b1, d);
    w = 0;
    sample(dut, b, l, dd, u, r);
    while (r !== 1'b1 && w < 3000) begin
      @(negedge clk);
      w++;
      sample(dut, b, l, dd, u, r);
    end
    chk("push_wait", 128'(w < 3000), 128'd1);
    acc_cyc.push_back(cyc);
    @(negedge clk);
    drive(dut, 1'b0, d);
    sample(dut, b, l, dd, u, r);
    chk("ready_drop", 128'(r), 128'd0);
  endtask

  // Receiver: n falling-edge samples, recording rising-BCK bits and underruns.
  task automatic run_cycles(input int dut, input int n);
    logic b, l, d, u, r, pb;
    rx_d.delete(); rx_l.delete(); rise_cyc.delete(); und_cyc.delete();
    first_fall = -1;
    sample(dut, pb, l, d, u, r);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      sample(dut, b, l, d, u, r);
      if (b && !pb) begin
        rx_d.push_back(d);
        rx_l.push_back(l);
        rise_cyc.push_back(i);
      end
      if (!b && pb && first_fall < 0) first_fall = i;
      if (u) und_cyc.push_back(i);
      pb = b;
    end
  endtask

  // Frame f packed MSB-first: frame bit p lands at [fb-1-p].
  function automatic logic [127:0] frame_of(input int f, input int fb, input bit lr);
    logic [127:0] v;
    v = '0;
    for (int p = 0; p < fb; p++) begin
      int idx;
      idx = 1 + f * fb + p;
      if (idx < rx_d.size()) v[fb-1-p] = lr ? rx_l[idx] : rx_d[idx];
      else                   v[fb-1-p] = 1'bx;
    end
    return v;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    logic b, l, d, u, r;

    vt[0] = '{0, 0, 96'h0001_A5F0, 128'hA5F00001, 128'hA5F00001, 1};
    vt[1] = '{0, 0, 96'h8000_0001, 128'h00018000, 128'h00018000, 1};
    vt[2] = '{0, 0, 96'hFFFF_0000, 128'h0000FFFF, 128'h0000FFFF, 1};
    vt[3] = '{1, 0, 96'h0001_A5F0, 128'h52F80000, 128'hD2F80000, 1};
    vt[4] = '{1, 0, 96'h8000_0001, 128'h0000C000, 128'h0000C000, 1};
    vt[5] = '{2, 0, 96'h00FF00_800001_ABCDEF_123456,
              128'h12345600_ABCDEF00_80000100_00FF0000,
              128'h12345600_ABCDEF00_80000100_00FF0000, 1};
    // accept lands on the empty-buffer frame start: frame 0 silent, frame 1 carries it
    vt[6] = '{2, 1, 96'h000001_FFFFFF_5A5A5A_C00003,
              128'h0,
              128'hC0000300_5A5A5A00_FFFFFF00_00000100, 1};

    reset_n = 1'b0;
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    drive(2, 1'b0, '0);
    repeat (2) @(negedge clk);

    // reset state
    for (int k = 0; k < 3; k++) begin
      sample(k, b, l, d, u, r);
      chk($sformatf("rst%0d_bck", k),   128'(b), 128'd0);
      chk($sformatf("rst%0d_lrck", k),  128'(l), 128'd0);
      chk($sformatf("rst%0d_data", k),  128'(d), 128'd0);
      chk($sformatf("rst%0d_und", k),   128'(u), 128'd0);
      chk($sformatf("rst%0d_ready", k), 128'(r), 128'd1);
    end

    // idle start-up: timing, silent data, one underrun per frame
    reset_n = 1'b1;
    run_cycles(0, 258);
    chk("idle_first_fall", 128'(first_fall), 128'd4);
    chk("idle_bck_period", 128'((rise_cyc.size() > 2) ? rise_cyc[2] - rise_cyc[1] : -1), 128'd4);
    chk("idle_frame0", frame_of(0, 32, 0), 128'd0);
    chk("idle_frame1", frame_of(1, 32, 0), 128'd0);
    chk("idle_und_count", 128'(und_cyc.size()), 128'd2);
    chk("idle_und_first", 128'((und_cyc.size() > 0) ? und_cyc[0] : -1), 128'd4);
    chk("idle_und_spacing", 128'((und_cyc.size() > 1) ? und_cyc[1] - und_cyc[0] : -1), 128'd128);

    // table of single-frame transfers, two frames observed each
    for (int i = 0; i < NV; i++) begin
      int dut, fb, n;
      dut = vt[i].dut;
      fb  = fb_of(dut);
      n   = div_of(dut) * (4 * fb + 1);
      do_reset();
      fork
        push(dut, vt[i].din, vt[i].pre);
        run_cycles(dut, n);
      join
      chk($sformatf("v%0d_frame0", i), frame_of(0, fb, 0), vt[i].exp0);
      chk($sformatf("v%0d_frame1", i), frame_of(1, fb, 0), vt[i].exp1);
      chk($sformatf("v%0d_lrck0", i),  frame_of(0, fb, 1), lrck_exp(fb));
      chk($sformatf("v%0d_lrck1", i),  frame_of(1, fb, 1), lrck_exp(fb));
      chk($sformatf("v%0d_und", i),    128'(und_cyc.size()), 128'(vt[i].und));
      sample(dut, b, l, d, u, r);
      chk($sformatf("v%0d_ready_end", i), 128'(r), 128'd1);
    end

    // TDM back-pressure: four frames offered back to back
    do_reset();
    acc_cyc.delete();
    exp_q.delete();
    exp_q.push_back(128'h11111100_22222200_33333300_44444400);
    exp_q.push_back(128'hF0F0F000_0F0F0F00_AAAAAA00_55555500);
    exp_q.push_back(128'h80000000_00000100_7FFFFF00_FFFFFE00);
    exp_q.push_back(128'h13579B00_2468AC00_FEDCBA00_01234500);
    fork
      begin
        push(2, 96'h444444_333333_222222_111111, 0);
        push(2, 96'h555555_AAAAAA_0F0F0F_F0F0F0, 0);
        push(2, 96'hFFFFFE_7FFFFF_000001_800000, 0);
        push(2, 96'h012345_FEDCBA_2468AC_13579B, 0);
      end
      run_cycles(2, 1025);
    join
    chk("bp_accepts", 128'(acc_cyc.size()), 128'd4);
    chk("bp_gap_23", 128'((acc_cyc.size() > 2) ? acc_cyc[2] - acc_cyc[1] : -1), 128'd256);
    chk("bp_gap_34", 128'((acc_cyc.size() > 3) ? acc_cyc[3] - acc_cyc[2] : -1), 128'd256);
    for (int f = 0; f < 4; f++) begin
      logic [127:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
      chk($sformatf("bp_frame%0d", f), frame_of(f, 128, 0), e);
    end
    chk("bp_lrck", frame_of(0, 128, 1), lrck_exp(128));
    chk("bp_und", 128'(und_cyc.size()), 128'd0);

    // reset asserted at frame bit 37
    do_reset();
    fork
      push(0, 96'h1234_5678, 0);
      run_cycles(0, 152);
    join
    chk("abort_rst_pre_data", 128'(dat_a), 128'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_rst_bck",   128'(bck_a),  128'd0);
    chk("abort_rst_data",  128'(dat_a),  128'd0);
    chk("abort_rst_lrck",  128'(lrck_a), 128'd0);
    chk("abort_rst_ready", 128'(rdy_a),  128'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_cycles(0, 130);
    chk("abort_rst_first_fall", 128'(first_fall), 128'd4);
    chk("abort_rst_frame0", frame_of(0, 32, 0), 128'd0);
    chk("abort_rst_und", 128'(und_cyc.size()), 128'd1);

    // en dropped at frame bit 37 with a frame waiting in the buffer
    do_reset();
    fork
      begin
        push(0, 96'h0000_0000, 0);
        push(0, 96'hFFFF_FFFF, 0);
        push(0, 96'h0F0F_3C3C, 0);
      end
      run_cycles(0, 152);
    join
    chk("abort_en_pre_data", 128'(dat_a), 128'd1);
    en_a = 1'b0;
    @(negedge clk);
    chk("abort_en_bck",   128'(bck_a),  128'd0);
    chk("abort_en_data",  128'(dat_a),  128'd0);
    chk("abort_en_lrck",  128'(lrck_a), 128'd0);
    chk("abort_en_ready", 128'(rdy_a),  128'd0);
    repeat (4) @(negedge clk);
    en_a = 1'b1;
    run_cycles(0, 130);
    chk("abort_en_first_fall", 128'(first_fall), 128'd4);
    chk("abort_en_frame0", frame_of(0, 32, 0), 128'h3C3C0F0F);
    chk("abort_en_und", 128'(und_cyc.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
